// File: rtl/io_bank_mmio.sv
// Memory-mapped switch/LED bank: synchronized and debounced switch groups with sticky
// change flags and an IRQ, plus LED groups with per-bit blink driven by a prescaler.
module io_bank_mmio #(
  parameter int               N_SW         = 2,
  parameter int               N_LED        = 2,
  parameter int               DEBOUNCE_CYC = 16,
  parameter int               DIV_W        = 24,
  parameter logic [DIV_W-1:0] DIV_RST      = '0
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 io_rd,
  input  logic                 io_wr,
  input  logic [7:0]           io_addr,
  input  logic [31:0]          io_wdata,
  output logic [31:0]          io_rdata,
  input  logic [16*N_SW-1:0]   sw_in,
  output logic [16*N_LED-1:0]  led_out,
  output logic                 sw_event_irq
);

  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  localparam logic [5:0] IDX_SW_EVENT  = 6'd32;
  localparam logic [5:0] IDX_BLINK_DIV = 6'd33;

  logic [16*N_SW-1:0] r_sync1;
  logic [16*N_SW-1:0] r_sync2;
  logic [15:0]        r_cand   [N_SW];
  logic [15:0]        r_stable [N_SW];
  logic [CNT_W-1:0]   r_cnt    [N_SW];
  logic [N_SW-1:0]    r_sw_event;

  logic [15:0]        r_led_data  [N_LED];
  logic [15:0]        r_led_blink [N_LED];
  logic [16*N_LED-1:0] r_led_out;
  logic [DIV_W-1:0]   r_blink_div;
  logic [DIV_W-1:0]   r_pcnt;
  logic               r_phase;

  logic [5:0]         w_widx;
  logic [N_SW-1:0]    w_ev_set;
  logic [N_SW-1:0]    w_ev_clr;
  logic               w_wr_div;
  logic [31:0]        w_rdata;
  logic               w_unused_bits;

  assign w_widx        = io_addr[7:2];
  assign w_wr_div      = io_wr && (w_widx == IDX_BLINK_DIV);
  assign w_ev_clr      = (io_wr && (w_widx == IDX_SW_EVENT)) ? io_wdata[N_SW-1:0] : '0;
  assign w_unused_bits = ^{io_addr[1:0], io_wdata};

  // A group's stable value is accepted on the edge where its hold counter reaches the end.
  always_comb begin
    w_ev_set = '0;
    for (int g = 0; g < N_SW; g++) begin
      if ((r_sync2[16*g +: 16] == r_cand[g]) && (r_cand[g] != r_stable[g]) &&
          (r_cnt[g] == CNT_LAST)) begin
        w_ev_set[g] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      for (int g = 0; g < N_SW; g++) begin
        r_cand[g]   <= '0;
        r_stable[g] <= '0;
        r_cnt[g]    <= '0;
      end
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      for (int g = 0; g < N_SW; g++) begin
        if (r_sync2[16*g +: 16] != r_cand[g]) begin
          r_cand[g] <= r_sync2[16*g +: 16];
          r_cnt[g]  <= '0;
        end else if (r_cand[g] != r_stable[g]) begin
          if (w_ev_set[g]) begin
            r_stable[g] <= r_cand[g];
            r_cnt[g]    <= '0;
          end else begin
            r_cnt[g] <= r_cnt[g] + CNT_W'(1);
          end
        end else begin
          r_cnt[g] <= '0;
        end
      end
    end
  end

  // Hardware set has priority over a same-cycle write-one-to-clear.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sw_event <= '0;
    end else begin
      r_sw_event <= (r_sw_event & ~w_ev_clr) | w_ev_set;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_blink_div <= DIV_RST;
      for (int g = 0; g < N_LED; g++) begin
        r_led_data[g]  <= '0;
        r_led_blink[g] <= '0;
      end
    end else if (io_wr) begin
      if (w_wr_div) begin
        r_blink_div <= io_wdata[DIV_W-1:0];
      end
      for (int g = 0; g < N_LED; g++) begin
        if (w_widx == 6'(16 + g)) begin
          r_led_data[g] <= io_wdata[15:0];
        end
        if (w_widx == 6'(24 + g)) begin
          r_led_blink[g] <= io_wdata[15:0];
        end
      end
    end
  end

  // A zero divider parks the phase high so blinking bits simply stay lit.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_wr_div || (r_blink_div == '0)) begin
      r_pcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_pcnt == r_blink_div) begin
      r_pcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_pcnt <= r_pcnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_led_out <= '0;
    end else begin
      for (int g = 0; g < N_LED; g++) begin
        r_led_out[16*g +: 16] <= r_led_data[g] & ~(r_led_blink[g] & {16{~r_phase}});
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (io_rd) begin
      for (int g = 0; g < N_SW; g++) begin
        if (w_widx == 6'(g)) begin
          w_rdata[15:0] = r_stable[g];
        end
      end
      for (int g = 0; g < N_LED; g++) begin
        if (w_widx == 6'(16 + g)) begin
          w_rdata[15:0] = r_led_data[g];
        end
        if (w_widx == 6'(24 + g)) begin
          w_rdata[15:0] = r_led_blink[g];
        end
      end
      if (w_widx == IDX_SW_EVENT) begin
        w_rdata[N_SW-1:0] = r_sw_event;
      end
      if (w_widx == IDX_BLINK_DIV) begin
        w_rdata[DIV_W-1:0] = r_blink_div;
      end
    end
  end

  assign io_rdata     = w_rdata;
  assign led_out      = r_led_out;
  assign sw_event_irq = |r_sw_event;

endmodule
